// File: rtl/mem_ahb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_ahb_if : AHB-Lite slave in front of a 1-cycle-latency byte-lane RAM
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_ahb_if #(
  parameter int WIDTH_AD = 10,
  parameter int WIDTH_DA = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [31:0]         HADDR,
  input  logic [WIDTH_DA-1:0] HWDATA,
  input  logic                HREADY,
  output logic [WIDTH_DA-1:0] HRDATA,
  output logic                HRESP,
  output logic                HREADYout,
  output logic [WIDTH_AD-1:0] WADDR,
  output logic [WIDTH_DA-1:0] WDATA,
  output logic [3:0]          WSTRB,
  output logic                WEN,
  output logic [WIDTH_AD-1:0] RADDR,
  output logic [3:0]          RSTRB,
  output logic                REN,
  input  logic [WIDTH_DA-1:0] RDATA
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_RSTALL = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH_AD-1:0] addr_q, addr_d;
  logic [3:0]          strb_q, strb_d;

  logic [3:0] ap_strb;
  logic       ap_legal;
  logic       ap_open;
  logic       accept;
  logic       hazard;
  logic       unused_bits;

  assign unused_bits = ^{HBURST, HTRANS[0], HADDR[31:WIDTH_AD]};

  // Lane decode and alignment check of the current address phase
  always_comb begin
    ap_strb  = 4'b0000;
    ap_legal = 1'b0;
    case (HSIZE)
      3'd0: begin
        ap_strb  = 4'b0001 << HADDR[1:0];
        ap_legal = 1'b1;
      end
      3'd1: begin
        ap_strb  = HADDR[1] ? 4'b1100 : 4'b0011;
        ap_legal = ~HADDR[0];
      end
      3'd2: begin
        ap_strb  = 4'b1111;
        ap_legal = (HADDR[1:0] == 2'b00);
      end
      default: begin
        ap_strb  = 4'b0000;
        ap_legal = 1'b0;
      end
    endcase
  end

  assign ap_open = (state_q == ST_IDLE) || (state_q == ST_WRITE) ||
                   (state_q == ST_READ) || (state_q == ST_ERR2);
  assign accept  = HSEL & HTRANS[1] & HREADY & ap_open;

  // A read issued during a write data phase sees pre-write RAM contents
  assign hazard = (state_q == ST_WRITE) &&
                  (HADDR[WIDTH_AD-1:2] == addr_q[WIDTH_AD-1:2]) &&
                  ((ap_strb & strb_q) != 4'b0000);

  always_comb begin
    state_d = ST_IDLE;
    addr_d  = addr_q;
    strb_d  = strb_q;
    if (accept) begin
      if (!ap_legal) begin
        state_d = ST_ERR1;
      end else begin
        addr_d = HADDR[WIDTH_AD-1:0];
        strb_d = ap_strb;
        if (HWRITE) begin
          state_d = ST_WRITE;
        end else if (hazard) begin
          state_d = ST_RSTALL;
        end else begin
          state_d = ST_READ;
        end
      end
    end else begin
      case (state_q)
        ST_RSTALL: state_d = ST_READ;
        ST_ERR1:   state_d = ST_ERR2;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      strb_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
    end
  end

  assign WEN   = HRESETn & (state_q == ST_WRITE);
  assign WADDR = addr_q;
  assign WSTRB = strb_q;
  assign WDATA = HWDATA;

  assign REN   = HRESETn & ((accept & ap_legal & ~HWRITE) | (state_q == ST_RSTALL));
  assign RADDR = (state_q == ST_RSTALL) ? addr_q : HADDR[WIDTH_AD-1:0];
  assign RSTRB = (state_q == ST_RSTALL) ? strb_q : ap_strb;

  assign HREADYout = ~HRESETn | ~((state_q == ST_RSTALL) || (state_q == ST_ERR1));
  assign HRESP     = HRESETn & ((state_q == ST_ERR1) || (state_q == ST_ERR2));
  assign HRDATA    = RDATA;

endmodule
`default_nettype wire
